ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard or mouse.
- Companion to the team's existing PS/2 device-to-host receive path. Shares the same bidirectional PS2_CLK/PS2_DATA pins through external open-drain pads.
- Runs the full inhibit / request-to-send / bit shift / ACK sequence. Reports completion or error to the system side.

---
 rtl/ps2_host_tx.sv | 144 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, device ACK.
// Optional transfer watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shift;
  logic [3:0]       idx;
  logic             data_low;
  logic             ack_err;
  logic             idle_seen;
  logic             clk_s1, sync_clk, sync_clk_d;
  logic             data_s1, sync_data;
  logic             fall;

  // Synchronizers reset to the idle-high bus level so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1     <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      data_s1    <= 1'b1;
      sync_data  <= 1'b1;
    end else begin
      clk_s1     <= ps2_clk_in;
      sync_clk   <= clk_s1;
      sync_clk_d <= sync_clk;
      data_s1    <= ps2_data_in;
      sync_data  <= data_s1;
    end
  end

  assign fall        = sync_clk_d & ~sync_clk;
  assign tx_ready    = (state == S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_RTS);
  assign ps2_data_oe = (state == S_RTS) || ((state == S_SHIFT) && data_low);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift     <= '0;
      idx       <= '0;
      data_low  <= 1'b0;
      ack_err   <= 1'b0;
      idle_seen <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shift <= {1'b1, ~^tx_data, tx_data};
            cnt   <= '0;
            state <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) state <= S_RTS;
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        S_RTS: begin
          // Start bit stays asserted into SHIFT until the first device clock.
          data_low <= 1'b1;
          idx      <= '0;
          cnt      <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fall) begin
            data_low <= ~shift[0];
            shift    <= {1'b0, shift[9:1]};
            idx      <= idx + 1'b1;
            if (idx == 4'd9) state <= S_ACK;
          end
        end
        S_ACK: begin
          if (fall) begin
            ack_err   <= sync_data;
            idle_seen <= 1'b0;
            state     <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (sync_clk && sync_data) begin
            idle_seen <= 1'b1;
            if (idle_seen) begin
              state   <= S_IDLE;
              tx_done <= ~ack_err;
              tx_err  <= ack_err;
            end
          end else begin
            idle_seen <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog shares the cycle counter, cleared on SHIFT entry; it overrides any completion.
      if ((state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE)) begin
        if (cnt == TMO_LAST) begin
          state    <= S_IDLE;
          data_low <= 1'b0;
          tx_done  <= 1'b0;
          tx_err   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the open-drain bus.
module tb_ps2_host_tx;
  localparam int unsigned INH = 50;
  localparam int unsigned TMO = 3000;
  localparam int unsigned H   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  int tests = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus observers sampled on the falling edge.
  int  cyc = 0;
  int  done_cnt = 0, err_cnt = 0, inh_cnt = 0, rts_cnt = 0;
  int  shift_cyc = 0, err_cyc = 0;
  logic prev_clk_oe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_clk_oe <= ps2_clk_oe;
    if (prev_clk_oe && !ps2_clk_oe) shift_cyc <= cyc;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
    if (ps2_clk_oe && ps2_data_oe) rts_cnt <= rts_cnt + 1;
  end

  // Expected frame as the device sees it: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  logic [9:0] rx_bits;
  logic       start_seen;

  task automatic dev_run(input bit ack_ok, input int nfalls, output bit ok);
    int n;
    ok = 1'b1;
    rx_bits = '0;
    start_seen = 1'b0;
    n = 0;
    while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) begin ok = 1'b0; return; end
    n = 0;
    while (ps2_clk_oe && n < int'(INH) + 50) begin @(negedge clk); n++; end
    if (ps2_clk_oe) begin ok = 1'b0; return; end
    start_seen = (ps2_data_in == 1'b0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10) begin
        dev_data = ack_ok ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) rx_bits[i] = ps2_data_in;
      repeat (H) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " ready_drop"}, 32'(tx_ready), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack_ok, input bit inject, input string tag);
    int d0 = done_cnt, e0 = err_cnt, i0 = inh_cnt, r0 = rts_cnt;
    int n;
    bit ok;
    send(d, tag);
    fork
      dev_run(ack_ok, 11, ok);
      begin
        if (inject) begin
          repeat (150) @(negedge clk);
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          repeat (8) @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    join
    check({tag, " device_handshake"}, 32'(ok), 32'd1);
    check({tag, " start_bit"}, 32'(start_seen), 32'd1);
    check({tag, " frame"}, 32'(rx_bits), 32'(frame_of(d)));
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 100) begin @(posedge clk); n++; end
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, 32'(done_cnt - d0), ack_ok ? 32'd1 : 32'd0);
    check({tag, " err_pulses"}, 32'(err_cnt - e0), ack_ok ? 32'd0 : 32'd1);
    check({tag, " inhibit_len"}, 32'(inh_cnt - i0), 32'(INH));
    check({tag, " rts_len"}, 32'(rts_cnt - r0), 32'd1);
    check({tag, " ready_back"}, 32'(tx_ready), 32'd1);
    check({tag, " lines_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  initial begin
    int i0;
    int n;
    int d0;
    int e0;
    bit ok;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("reset ready", 32'(tx_ready), 32'd1);
    check("reset pulses", {30'd0, tx_done, tx_err}, 32'd0);
    check("reset lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    xfer(8'hED, 1'b1, 1'b0, "ed");
    xfer(8'h00, 1'b1, 1'b0, "00");
    xfer(8'hFF, 1'b1, 1'b0, "ff");
    xfer(8'hF3, 1'b0, 1'b0, "nack");

    i0 = inh_cnt;
    xfer(8'hF4, 1'b1, 1'b1, "f4_ignore55");
    repeat (100) @(negedge clk);
    check("f4 no_queued_xfer", 32'(inh_cnt - i0), 32'(INH));
    check("f4 idle_after", 32'(tx_ready), 32'd1);

    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      xfer(d, ($urandom_range(0, 3) != 0), 1'b0, $sformatf("rand%0d_%02h", k, d));
    end

    // Abort during data bit 4 of 0xC3 (bit 4 = 0, so DATA is being pulled low).
    send(8'hC3, "abort");
    dev_run(1'b1, 5, ok);
    check("abort handshake", 32'(ok), 32'd1);
    check("abort data_low_before", 32'(ps2_data_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort lines_async", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("abort ready_async", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'hEE, 1'b1, 1'b0, "ee_after_reset");

    // Device stops clocking after data bit 3.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h3C, "stall");
    dev_run(1'b1, 4, ok);
    check("stall handshake", 32'(ok), 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (err_cnt == e0 && n < int'(TMO) + 200) begin @(posedge clk); n++; end
    repeat (2) @(negedge clk);
    check("timeout err_pulses", 32'(err_cnt - e0), 32'd1);
    check("timeout latency", 32'(err_cyc - shift_cyc), 32'(TMO));
    check("timeout no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout ready", 32'(tx_ready), 32'd1);
    check("timeout lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
`else
    repeat (TMO + 500) @(negedge clk);
    check("stall still_busy", 32'(tx_ready), 32'd0);
    check("stall no_err", 32'(err_cnt - e0), 32'd0);
    check("stall no_done", 32'(done_cnt - d0), 32'd0);
    check("stall clk_released", 32'(ps2_clk_oe), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif
    xfer(8'hFF, 1'b1, 1'b0, "ff_final");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
